ddr_arb_rr: RTL and testbench
=============================

// Module: ddr_arb_rr
// PURPOSE
//  N-channel arbiter granting exclusive access to the DDR user interface (MIG app port).
//  Generalises the two-channel write/read arbiter to CH_NUM requesters.
//  Supports round-robin or fixed priority, and a per-transaction watchdog timeout.
//  Sits between the channel controllers (wr/rd/refresh engines) and the DDR command mux.
// PARAMETERS
//  CH_NUM    4   number of requesting channels (>=2)
//  ID_W      2   width of grant_id; must equal $clog2(CH_NUM)
//  PRIO_MODE 0   0 = round-robin, 1 = fixed priority (ch0 highest)
//  TMO_W     16  width of watchdog counter
//  TMO_CYC   0   cycles allowed in BUSY before abort; 0 = timeout disabled
// PORTS
//  clk       in   1       system clock
//  rst       in   1       asynchronous reset, active-high
//  req       in   CH_NUM  level request per channel
//  done      in   CH_NUM  1-cycle completion pulse per channel
//  en        out  CH_NUM  1-cycle start pulse to granted channel (one-hot or zero)
//  grant     out  CH_NUM  level, one-hot: channel owning the interface, ISSUE..BUSY
//  grant_id  out  ID_W    binary index of current/last grant
//  busy      out  1       high while state is ISSUE or BUSY
//  tmo_err   out  1       1-cycle pulse when a transaction is aborted by timeout
// BEHAVIOUR
//  Reset: async on rst high. State = IDLE; en, grant, grant_id, busy, tmo_err = 0.
//   RR pointer = 0; watchdog counter = 0. All outputs are registered.
//  FSM (one-hot, 4 states):
//   IDLE  -> ARB unconditionally on the next clk.
//   ARB   -> if |req: latch winner w; go to ISSUE. Otherwise stay.
//   ISSUE -> exactly 1 cycle: en[w] = 1, grant[w] = 1, busy = 1; then BUSY.
//            If done[w] is high in this cycle, go straight to ARB.
//   BUSY  -> grant[w] held. On done[w], go to ARB. On timeout, go to ARB.
//   Illegal state -> IDLE.
//  Latency: req sampled in ARB at edge t; en[w] is high in cycle t+1.
//   Back-to-back grants: done at edge t, ARB at t+1, next en at t+2.
//  Winner selection:
//   PRIO_MODE=0: first asserted req scanning ptr, ptr+1, ... mod CH_NUM.
//    On entering ISSUE, ptr <= (w+1) mod CH_NUM; wrap from CH_NUM-1 to 0.
//   PRIO_MODE=1: lowest-index asserted req; ptr unused.
//  done handling:
//   done bits of non-granted channels are ignored.
//   done while in IDLE or ARB is ignored.
//  req handling: deassertion of req[w] after ISSUE does not abort; the FSM waits for done or timeout.
//  Watchdog (TMO_CYC>0): counter clears on ISSUE and increments each BUSY cycle.
//   When count == TMO_CYC-1 and done[w] is low: tmo_err pulses 1 cycle, grant is released, FSM returns to ARB.
//   If done[w] and the timeout coincide, done wins and there is no tmo_err.
//  grant_id keeps its last value in ARB/IDLE. grant = 0 and busy = 0 outside ISSUE/BUSY.
//  rst asserted mid-transaction: immediate return to reset values; no en/done replay.
// TESTING
//  1 Reset, req=4'b0100 -> en=4'b0100 exactly 1 cycle, 2 cycles after ARB entry.
//    grant_id=2; done[2] -> grant=0, busy=0.
//  2 RR mode, req=4'b1111 held, immediate done each grant -> grant order 0,1,2,3,0; no channel granted twice in a row.
//  3 PRIO_MODE=1, req=4'b1010 held -> ch1 always wins; ch3 is never granted while req[1] is high.
//  4 TMO_CYC=8, grant ch0, no done -> tmo_err 1 pulse after 8 BUSY cycles, then FSM back in ARB.
//    Also: done on that same cycle -> no tmo_err.
//  5 grant ch1, pulse done[2] and done[0] -> ignored, grant stays 4'b0010.
//    Then done[1] -> release.
//  6 rst high during BUSY -> en/grant/busy=0 same cycle.
//    After rst low: IDLE->ARB, ptr=0, so req=4'b1111 grants ch0.

Source files
------------

// File: rtl/ddr_arb_rr.sv
// N-channel arbiter for the DDR user interface: round-robin or fixed priority,
// one transaction at a time, with an optional per-transaction watchdog.
module ddr_arb_rr #(
  parameter int unsigned CH_NUM    = 4,
  parameter int unsigned ID_W      = 2,
  parameter int unsigned PRIO_MODE = 0,
  parameter int unsigned TMO_W     = 16,
  parameter int unsigned TMO_CYC   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CH_NUM-1:0] req,
  input  logic [CH_NUM-1:0] done,
  output logic [CH_NUM-1:0] en,
  output logic [CH_NUM-1:0] grant,
  output logic [ID_W-1:0]   grant_id,
  output logic              busy,
  output logic              tmo_err
);

  typedef enum logic [3:0] {
    StIdle  = 4'b0001,
    StArb   = 4'b0010,
    StIssue = 4'b0100,
    StBusy  = 4'b1000
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic [CH_NUM-1:0]   en_q, en_d;
  logic [CH_NUM-1:0]   grant_q, grant_d;
  logic                busy_q, busy_d;
  logic                tmo_q, tmo_d;

  logic [ID_W-1:0]     win;
  logic                win_vld;
  logic [CH_NUM-1:0]   win_oh;
  logic                done_own;
  logic                tmo_hit;

  // Winner selection: lowest index in fixed mode, first hit from ptr in round-robin.
  always_comb begin
    int idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = 0;
    if (PRIO_MODE != 0) begin
      for (int i = int'(CH_NUM) - 1; i >= 0; i--) begin
        if (req[i]) begin
          win     = ID_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = 0; k < int'(CH_NUM); k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= int'(CH_NUM)) idx = idx - int'(CH_NUM);
        if (!win_vld && req[idx]) begin
          win     = ID_W'(idx);
          win_vld = 1'b1;
        end
      end
    end
    win_oh      = '0;
    win_oh[win] = 1'b1;
  end

  assign done_own = done[gid_q];
  assign tmo_hit  = (TMO_CYC != 0) && (cnt_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    grant_d = grant_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        state_d = StArb;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      StArb: begin
        grant_d = '0;
        busy_d  = 1'b0;
        if (win_vld) begin
          state_d = StIssue;
          gid_d   = win;
          en_d    = win_oh;
          grant_d = win_oh;
          busy_d  = 1'b1;
          if (PRIO_MODE == 0) begin
            ptr_d = (win == ID_W'(CH_NUM - 1)) ? '0 : win + ID_W'(1);
          end
        end
      end
      StIssue: begin
        cnt_d = '0;
        if (done_own) begin
          state_d = StArb;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          state_d = StBusy;
        end
      end
      StBusy: begin
        // done takes precedence over a coincident timeout
        if (done_own) begin
          state_d = StArb;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (tmo_hit) begin
          state_d = StArb;
          grant_d = '0;
          busy_d  = 1'b0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + TMO_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      en_q    <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign en       = en_q;
  assign grant    = grant_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign tmo_err  = tmo_q;

endmodule

// File: tb/tb_ddr_arb_rr.sv
// Randomized bench: a round-robin/watchdog instance and a fixed-priority instance,
// each compared cycle by cycle against a transaction-level reference model.
module tb_ddr_arb_rr;

  localparam int PhIdle  = 0;
  localparam int PhArb   = 1;
  localparam int PhIssue = 2;
  localparam int PhBusy  = 3;
  localparam int NCyc    = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_v  [2];
  logic [3:0] done_v [2];
  logic [3:0] en_w   [2];
  logic [3:0] grant_w[2];
  logic [1:0] gid_w  [2];
  logic       busy_w [2];
  logic       tmo_w  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, one slot per instance (0 = RR/TMO 8, 1 = fixed prio/no TMO)
  int m_phase[2];
  int m_owner[2];
  int m_ptr  [2];
  int m_wait [2];
  bit m_tmo  [2];

  always #5 clk = ~clk;

  ddr_arb_rr #(.CH_NUM(4), .ID_W(2), .PRIO_MODE(0), .TMO_W(16), .TMO_CYC(8)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req_v[0]),
    .done     (done_v[0]),
    .en       (en_w[0]),
    .grant    (grant_w[0]),
    .grant_id (gid_w[0]),
    .busy     (busy_w[0]),
    .tmo_err  (tmo_w[0])
  );

  ddr_arb_rr #(.CH_NUM(4), .ID_W(2), .PRIO_MODE(1), .TMO_W(16), .TMO_CYC(0)) u_fp (
    .clk      (clk),
    .rst      (rst),
    .req      (req_v[1]),
    .done     (done_v[1]),
    .en       (en_w[1]),
    .grant    (grant_w[1]),
    .grant_id (gid_w[1]),
    .busy     (busy_w[1]),
    .tmo_err  (tmo_w[1])
  );

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tmo_limit(int d);
    return (d == 0) ? 8 : 0;
  endfunction

  function automatic int pick(int d, logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (d == 1) ? k : (m_ptr[d] + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset(int d);
    m_phase[d] = PhIdle;
    m_owner[d] = 0;
    m_ptr[d]   = 0;
    m_wait[d]  = 0;
    m_tmo[d]   = 1'b0;
  endtask

  task automatic model_step(int d, logic [3:0] r, logic [3:0] dn);
    int w;
    m_tmo[d] = 1'b0;
    case (m_phase[d])
      PhIdle: m_phase[d] = PhArb;
      PhArb: begin
        w = pick(d, r);
        if (w >= 0) begin
          m_owner[d] = w;
          if (d == 0) m_ptr[d] = (w + 1) % 4;
          m_phase[d] = PhIssue;
        end
      end
      PhIssue: begin
        m_wait[d]  = 0;
        m_phase[d] = dn[m_owner[d]] ? PhArb : PhBusy;
      end
      default: begin
        m_wait[d] = m_wait[d] + 1;
        if (dn[m_owner[d]]) begin
          m_phase[d] = PhArb;
        end else if (tmo_limit(d) > 0 && m_wait[d] == tmo_limit(d)) begin
          m_phase[d] = PhArb;
          m_tmo[d]   = 1'b1;
        end
      end
    endcase
  endtask

  task automatic check_dut(int d, int cyc);
    logic [3:0] oh;
    string      nm;
    oh = 4'b0001 << m_owner[d];
    nm = (d == 0) ? "rr" : "fp";
    check_eq($sformatf("%s.en@%0d", nm, cyc), 32'(en_w[d]),
             (m_phase[d] == PhIssue) ? 32'(oh) : 32'd0);
    check_eq($sformatf("%s.grant@%0d", nm, cyc), 32'(grant_w[d]),
             (m_phase[d] == PhIssue || m_phase[d] == PhBusy) ? 32'(oh) : 32'd0);
    check_eq($sformatf("%s.busy@%0d", nm, cyc), 32'(busy_w[d]),
             32'(m_phase[d] == PhIssue || m_phase[d] == PhBusy));
    check_eq($sformatf("%s.grant_id@%0d", nm, cyc), 32'(gid_w[d]), 32'(m_owner[d]));
    check_eq($sformatf("%s.tmo_err@%0d", nm, cyc), 32'(tmo_w[d]), 32'(m_tmo[d]));
  endtask

  // Builds this cycle's inputs; done on a non-owner channel is always random noise.
  task automatic gen_stim(int d, int cyc);
    logic [3:0] oh;
    logic [3:0] r;
    bit         own;
    oh  = 4'b0001 << m_owner[d];
    own = 1'b0;
    if (cyc >= 600 && cyc < 900) begin
      req_v[d] = (d == 1) ? 4'b1010 : 4'b1111;
      own      = 1'b1;
    end else begin
      if ($urandom_range(0, 3) == 0 || req_v[d] == 4'b0000) begin
        r        = 4'($urandom_range(0, 15));
        req_v[d] = r;
      end
      if (cyc >= 900 && cyc < 1400 && d == 0) begin
        // Done only ever arrives on the would-be timeout cycle, half the time
        own = (m_phase[d] == PhBusy) && (m_wait[d] + 1 == 8) && ($urandom_range(0, 1) == 1);
      end else begin
        own = ($urandom_range(0, 3) == 0);
      end
    end
    r         = 4'($urandom_range(0, 15)) & ~oh;
    done_v[d] = r | (own ? oh : 4'b0000);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_v[d]  = 4'b0000;
      done_v[d] = 4'b0000;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    for (int cyc = 0; cyc < NCyc; cyc++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check_dut(d, cyc);
      if (cyc >= 1400 && $urandom_range(0, 49) == 0) begin
        // Asynchronous reset mid-run: outputs must clear without waiting for a clock
        rst = 1'b1;
        for (int d = 0; d < 2; d++) model_reset(d);
        #1;
        for (int d = 0; d < 2; d++) check_dut(d, cyc);
        continue;
      end
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
        gen_stim(d, cyc);
        model_step(d, req_v[d], done_v[d]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
